mk8_param_ram_arbiter: RTL and testbench

MK8_PARAM_RAM_ARBITER -- requirements
Module: mk8_param_ram_arbiter

---
 rtl/mk8_param_ram_arbiter_if.sv | 64 ++++++
 rtl/mk8_param_ram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mk8_param_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mk8_param_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : mk8_param_ram_arbiter_if
// Description: Bus bundle for the two-requester RAM arbiter. Carries both
//              Avalon-MM requester ports (A and B, A with a lock request),
//              the single RAM port and the sticky range-error flag.
//              modport slave  : the arbiter's view (requesters in, RAM out)
//              modport master : the environment's view (requesters out, RAM in)
// Revision   : 1.0 - initial release
// ============================================================================
interface mk8_param_ram_arbiter_if;
  // requester A
  logic [10:0] a_address;
  logic        a_read;
  logic        a_write;
  logic [31:0] a_writedata;
  logic [3:0]  a_byteenable;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic        a_lock;
  // requester B
  logic [10:0] b_address;
  logic        b_read;
  logic        b_write;
  logic [31:0] b_writedata;
  logic [3:0]  b_byteenable;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  // RAM port
  logic [10:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_readdata;
  // status
  logic        range_error;
  logic        range_error_clr;

  modport slave (
    input  a_address, a_read, a_write, a_writedata, a_byteenable, a_lock,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_read, b_write, b_writedata, b_byteenable,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
    input  ram_readdata,
    output range_error,
    input  range_error_clr
  );

  modport master (
    output a_address, a_read, a_write, a_writedata, a_byteenable, a_lock,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_read, b_write, b_writedata, b_byteenable,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
    output ram_readdata,
    input  range_error,
    output range_error_clr
  );
endinterface
`default_nettype wire

// File: rtl/mk8_param_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : mk8_param_ram_arbiter
// Description: Round-robin arbiter sharing one single-port RAM between two
//              Avalon-MM requesters. One transfer is issued per cycle, writes
//              complete in the grant cycle, reads return exactly one cycle
//              later to the side that issued them. Accesses at or beyond
//              DEPTH are suppressed and flagged on a sticky range_error.
// Parameters : DEPTH    - number of valid RAM words (default 1025)
//              LOCK_MAX - max cycles requester A may own the RAM under lock
//                         (default 64, must be >= 2)
// Ports      : clk, reset (async, active high)
//              bus.slave - requester A/B ports, RAM port, range_error(_clr)
// Option     : MK8_PARAM_ARB_LOCK_EN - when defined, adds the A lock FSM
//              (UNLOCKED -> LOCKED -> COOLDOWN); otherwise a_lock is ignored.
// Revision   : 1.0 - initial release
// ============================================================================
module mk8_param_ram_arbiter #(
  parameter int DEPTH    = 1025,
  parameter int LOCK_MAX = 64
) (
  input logic                    clk,
  input logic                    reset,
  mk8_param_ram_arbiter_if.slave bus
);

  logic        w_a_req;
  logic        w_b_req;
  logic        w_rr_pick_a;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_issue;
  logic [10:0] w_sel_addr;
  logic        w_sel_wr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_be;
  logic        w_in_range;

  logic        r_ready;         // low for the first cycle after reset
  logic        r_last_grant_b;  // side of the most recently issued transfer
  logic        r_rv_a;          // read in flight owned by A
  logic        r_rv_b;          // read in flight owned by B
  logic        r_rv_oor;        // read in flight was out of range -> data 0
  logic        r_range_error;
  logic [10:0] r_hold_addr;
  logic [31:0] r_hold_wdata;
  logic [3:0]  r_hold_be;

  assign w_a_req = bus.a_read | bus.a_write;
  assign w_b_req = bus.b_read | bus.b_write;

  // Under contention, favour the side that did not win last time.
  always_comb begin
    w_rr_pick_a = w_a_req;
    if (w_a_req && w_b_req) begin
      w_rr_pick_a = r_last_grant_b;
    end
  end

`ifdef MK8_PARAM_ARB_LOCK_EN
  localparam int C_CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_COOLDOWN = 2'd2
  } lock_state_t;

  lock_state_t        r_lock_state;
  lock_state_t        w_lock_state;
  // Number of cycles A has owned the RAM in the current lock, counting the
  // acquiring grant cycle, so the final LOCKED cycle is A's LOCK_MAX-th.
  logic [C_CNT_W-1:0] r_lock_cnt;
  logic [C_CNT_W-1:0] w_lock_cnt;

  always_comb begin
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_lock_state = r_lock_state;
    w_lock_cnt   = r_lock_cnt;
    if (r_ready) begin
      case (r_lock_state)
        ST_LOCKED: begin
          // B is stalled for the whole LOCKED state, even on the release cycle.
          w_grant_a  = w_a_req;
          w_lock_cnt = r_lock_cnt + C_CNT_W'(1);
          if (!bus.a_lock) begin
            w_lock_state = ST_UNLOCKED;
            w_lock_cnt   = '0;
          end else if (r_lock_cnt == C_CNT_W'(LOCK_MAX - 1)) begin
            w_lock_state = ST_COOLDOWN;
            w_lock_cnt   = '0;
          end
        end
        ST_COOLDOWN: begin
          // B is served first; A may only use the slot if B is idle and
          // cannot take a new lock from here.
          if (w_b_req) begin
            w_grant_b = 1'b1;
          end else begin
            w_grant_a = w_a_req;
          end
          w_lock_state = ST_UNLOCKED;
        end
        default: begin
          w_grant_a = w_a_req & w_rr_pick_a;
          w_grant_b = w_b_req & ~w_rr_pick_a;
          if (w_grant_a && bus.a_lock) begin
            w_lock_state = ST_LOCKED;
            w_lock_cnt   = C_CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_state <= ST_UNLOCKED;
      r_lock_cnt   <= '0;
    end else begin
      r_lock_state <= w_lock_state;
      r_lock_cnt   <= w_lock_cnt;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = bus.a_lock;

  assign w_grant_a = r_ready & w_a_req & w_rr_pick_a;
  assign w_grant_b = r_ready & w_b_req & ~w_rr_pick_a;
`endif

  assign w_issue = w_grant_a | w_grant_b;

  // Read+write together is treated as a write.
  assign w_sel_addr  = w_grant_b ? bus.b_address    : bus.a_address;
  assign w_sel_wr    = w_grant_b ? bus.b_write      : bus.a_write;
  assign w_sel_wdata = w_grant_b ? bus.b_writedata  : bus.a_writedata;
  assign w_sel_be    = w_grant_b ? bus.b_byteenable : bus.a_byteenable;
  assign w_in_range  = ({21'd0, w_sel_addr} < 32'(DEPTH));

  // RAM port: address/data/byteenable hold their last value when idle.
  assign bus.ram_address    = w_issue ? w_sel_addr  : r_hold_addr;
  assign bus.ram_writedata  = w_issue ? w_sel_wdata : r_hold_wdata;
  assign bus.ram_byteenable = w_issue ? w_sel_be    : r_hold_be;
  assign bus.ram_chipselect = w_issue & w_in_range;
  assign bus.ram_write      = w_issue & w_in_range & w_sel_wr;

  // r_ready is low in reset and the cycle after, forcing waitrequest high.
  assign bus.a_waitrequest = ~r_ready | (w_a_req & ~w_grant_a);
  assign bus.b_waitrequest = ~r_ready | (w_b_req & ~w_grant_b);

  assign bus.a_readdatavalid = r_rv_a;
  assign bus.b_readdatavalid = r_rv_b;
  assign bus.a_readdata      = (r_rv_a & ~r_rv_oor) ? bus.ram_readdata : 32'd0;
  assign bus.b_readdata      = (r_rv_b & ~r_rv_oor) ? bus.ram_readdata : 32'd0;

  assign bus.range_error = r_range_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready        <= 1'b0;
      r_last_grant_b <= 1'b1;
      r_rv_a         <= 1'b0;
      r_rv_b         <= 1'b0;
      r_rv_oor       <= 1'b0;
      r_range_error  <= 1'b0;
      r_hold_addr    <= '0;
      r_hold_wdata   <= '0;
      r_hold_be      <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_rv_a   <= w_grant_a & ~w_sel_wr;
      r_rv_b   <= w_grant_b & ~w_sel_wr;
      r_rv_oor <= ~w_in_range;
      if (w_issue) begin
        r_last_grant_b <= w_grant_b;
        r_hold_addr    <= w_sel_addr;
        r_hold_wdata   <= w_sel_wdata;
        r_hold_be      <= w_sel_be;
      end
      // A new error wins over a simultaneous clear.
      if (w_issue && !w_in_range) begin
        r_range_error <= 1'b1;
      end else if (bus.range_error_clr) begin
        r_range_error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mk8_param_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_mk8_param_ram_arbiter
// Description: Self-checking bench for mk8_param_ram_arbiter. A cycle table
//              of requester stimulus and expected outputs, followed by
//              hand-written reset-during-read, sustained write stream and
//              (with MK8_PARAM_ARB_LOCK_EN) lock sequences. A behavioural
//              synchronous-read RAM sits on the RAM port.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mk8_param_ram_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  mk8_param_ram_arbiter_if bus ();

  mk8_param_ram_arbiter #(.DEPTH(1025), .LOCK_MAX(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Behavioural RAM: read data appears one cycle after the address.
  logic [31:0] mem [2048];
  logic [31:0] ram_q = 32'd0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else if (bus.ram_chipselect) begin
      if (bus.ram_write) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.ram_byteenable[k]) mem[bus.ram_address][8*k +: 8] <= bus.ram_writedata[8*k +: 8];
        end
      end else begin
        ram_q <= mem[bus.ram_address];
      end
    end
  end
  assign bus.ram_readdata = ram_q;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    req_t        a;
    req_t        b;
    logic        clr;
    logic        aw, bw, cs, we;
    int          addr;   // -1: address not checked
    logic        arv;
    logic [31:0] ard;
    logic        brv;
    logic [31:0] brd;
    logic        rerr;
  } vec_t;

  function automatic req_t IDLE();
    return '0;
  endfunction
  function automatic req_t RD(input int a);
    return '{rd: H, wr: L, addr: 11'(a), wd: 32'd0, be: 4'hF};
  endfunction
  function automatic req_t WR(input int a, input logic [31:0] d, input logic [3:0] be);
    return '{rd: L, wr: H, addr: 11'(a), wd: d, be: be};
  endfunction
  function automatic req_t RW(input int a, input logic [31:0] d);
    return '{rd: H, wr: H, addr: 11'(a), wd: d, be: 4'hF};
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input req_t a, input req_t b, input logic clr, input logic lk);
    bus.a_read = a.rd;  bus.a_write = a.wr;  bus.a_address = a.addr;
    bus.a_writedata = a.wd;  bus.a_byteenable = a.be;  bus.a_lock = lk;
    bus.b_read = b.rd;  bus.b_write = b.wr;  bus.b_address = b.addr;
    bus.b_writedata = b.wd;  bus.b_byteenable = b.be;
    bus.range_error_clr = clr;
  endtask

  vec_t vt [24];

  initial begin
    // row: A req, B req, clr | aw bw cs we addr | arv ard | brv brd | rerr
    vt[0]  = '{RD(5),    RD(9),    L, H,H,L,L, 0,    L,32'd0,        L,32'd0,        L};
    vt[1]  = '{RD(5),    RD(9),    L, L,H,H,L, 5,    L,32'd0,        L,32'd0,        L};
    vt[2]  = '{IDLE(),   RD(9),    L, L,L,H,L, 9,    H,pat(5),       L,32'd0,        L};
    vt[3]  = '{IDLE(),   IDLE(),   L, L,L,L,L, 9,    L,32'd0,        H,pat(9),       L};
    vt[4]  = '{WR(0,32'h11223344,4'hF), IDLE(), L, L,L,H,H, 0, L,32'd0, L,32'd0,     L};
    vt[5]  = '{WR(0,32'hDEADBEEF,4'h3), IDLE(), L, L,L,H,H, 0, L,32'd0, L,32'd0,     L};
    vt[6]  = '{RD(0),    IDLE(),   L, L,L,H,L, 0,    L,32'd0,        L,32'd0,        L};
    vt[7]  = '{IDLE(),   IDLE(),   L, L,L,L,L, 0,    H,32'h1122BEEF, L,32'd0,        L};
    vt[8]  = '{IDLE(),   RD(1025), L, L,L,L,L, -1,   L,32'd0,        L,32'd0,        L};
    vt[9]  = '{IDLE(),   IDLE(),   L, L,L,L,L, -1,   L,32'd0,        H,32'd0,        H};
    vt[10] = '{IDLE(),   IDLE(),   H, L,L,L,L, -1,   L,32'd0,        L,32'd0,        H};
    vt[11] = '{IDLE(),   IDLE(),   L, L,L,L,L, -1,   L,32'd0,        L,32'd0,        L};
    vt[12] = '{RD(2000), IDLE(),   H, L,L,L,L, -1,   L,32'd0,        L,32'd0,        L};
    vt[13] = '{IDLE(),   IDLE(),   L, L,L,L,L, -1,   H,32'd0,        L,32'd0,        H};
    vt[14] = '{IDLE(),   IDLE(),   H, L,L,L,L, -1,   L,32'd0,        L,32'd0,        H};
    vt[15] = '{IDLE(),   IDLE(),   L, L,L,L,L, -1,   L,32'd0,        L,32'd0,        L};
    vt[16] = '{IDLE(),   RD(1024), L, L,L,H,L, 1024, L,32'd0,        L,32'd0,        L};
    vt[17] = '{IDLE(),   IDLE(),   L, L,L,L,L, 1024, L,32'd0,        H,pat(1024),    L};
    vt[18] = '{IDLE(),   RW(7,32'h55AA55AA), L, L,L,H,H, 7, L,32'd0, L,32'd0,        L};
    vt[19] = '{IDLE(),   RD(7),    L, L,L,H,L, 7,    L,32'd0,        L,32'd0,        L};
    vt[20] = '{RD(3),    RD(4),    L, L,H,H,L, 3,    L,32'd0,        H,32'h55AA55AA, L};
    vt[21] = '{RD(6),    RD(4),    L, H,L,H,L, 4,    H,pat(3),       L,32'd0,        L};
    vt[22] = '{RD(6),    IDLE(),   L, L,L,H,L, 6,    L,32'd0,        H,pat(4),       L};
    vt[23] = '{IDLE(),   IDLE(),   L, L,L,L,L, 6,    H,pat(6),       L,32'd0,        L};
  end

  initial begin
    int a_k, b_k, writes, alt_err, first_a, b_cycle;
    logic ga, gb, prev_a;

    drive(IDLE(), IDLE(), L, L);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst a_waitrequest", 32'(bus.a_waitrequest), 32'd1);
    chk("rst b_waitrequest", 32'(bus.b_waitrequest), 32'd1);
    chk("rst a_readdatavalid", 32'(bus.a_readdatavalid), 32'd0);
    chk("rst b_readdatavalid", 32'(bus.b_readdatavalid), 32'd0);
    chk("rst a_readdata", bus.a_readdata, 32'd0);
    chk("rst b_readdata", bus.b_readdata, 32'd0);
    chk("rst ram_chipselect", 32'(bus.ram_chipselect), 32'd0);
    chk("rst ram_write", 32'(bus.ram_write), 32'd0);
    chk("rst range_error", 32'(bus.range_error), 32'd0);

    // ---------------- cycle table ----------------
    @(posedge clk); #1;
    reset = 1'b0;
    mem_init = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].clr, L);
      @(negedge clk);
      chk($sformatf("r%0d a_waitrequest", i), 32'(bus.a_waitrequest), 32'(vt[i].aw));
      chk($sformatf("r%0d b_waitrequest", i), 32'(bus.b_waitrequest), 32'(vt[i].bw));
      chk($sformatf("r%0d ram_chipselect", i), 32'(bus.ram_chipselect), 32'(vt[i].cs));
      chk($sformatf("r%0d ram_write", i), 32'(bus.ram_write), 32'(vt[i].we));
      if (vt[i].addr >= 0)
        chk($sformatf("r%0d ram_address", i), 32'(bus.ram_address), 32'(vt[i].addr));
      chk($sformatf("r%0d a_readdatavalid", i), 32'(bus.a_readdatavalid), 32'(vt[i].arv));
      chk($sformatf("r%0d a_readdata", i), bus.a_readdata, vt[i].ard);
      chk($sformatf("r%0d b_readdatavalid", i), 32'(bus.b_readdatavalid), 32'(vt[i].brv));
      chk($sformatf("r%0d b_readdata", i), bus.b_readdata, vt[i].brd);
      chk($sformatf("r%0d range_error", i), 32'(bus.range_error), 32'(vt[i].rerr));
      @(posedge clk); #1;
    end

    // ---------------- reset during a read ----------------
    drive(RD(10), IDLE(), L, L);
    @(negedge clk);
    chk("mid-read grant", 32'(bus.a_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(IDLE(), IDLE(), L, L);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("mid-read rst%0d a_readdatavalid", i), 32'(bus.a_readdatavalid), 32'd0);
      chk($sformatf("mid-read rst%0d a_readdata", i), bus.a_readdata, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst startup a_waitrequest", 32'(bus.a_waitrequest), 32'd1);
    chk("post-rst startup b_waitrequest", 32'(bus.b_waitrequest), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post-rst%0d a_readdatavalid", i), 32'(bus.a_readdatavalid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;

    // ---------------- sustained two-requester write stream ----------------
    a_k = 0; b_k = 0; writes = 0; alt_err = 0; first_a = 0; prev_a = L;
    for (int c = 0; c < 100; c++) begin
      drive(WR(100 + a_k, 32'hA000_0000 + 32'(a_k), 4'hF),
            WR(400 + b_k, 32'hB000_0000 + 32'(b_k), 4'hF), L, L);
      @(negedge clk);
      ga = ~bus.a_waitrequest;
      gb = ~bus.b_waitrequest;
      if (ga == gb) alt_err++;
      if (bus.ram_chipselect && bus.ram_write) writes++;
      if (c == 0) first_a = int'(ga);
      else if (ga == prev_a) alt_err++;
      prev_a = ga;
      @(posedge clk); #1;
      if (ga) a_k++;
      if (gb) b_k++;
    end
    drive(IDLE(), IDLE(), L, L);
    @(negedge clk);
    chk("stream first grant A", 32'(first_a), 32'd1);
    chk("stream alternation errors", 32'(alt_err), 32'd0);
    chk("stream ram writes", 32'(writes), 32'd100);
    chk("stream A accepted", 32'(a_k), 32'd50);
    chk("stream B accepted", 32'(b_k), 32'd50);
    chk("stream mem A last", mem[149], 32'hA000_0031);
    chk("stream mem B last", mem[449], 32'hB000_0031);
    chk("stream mem A untouched", mem[150], pat(150));
    @(posedge clk); #1;

`ifdef MK8_PARAM_ARB_LOCK_EN
    // ---------------- lock with B contending ----------------
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(RD(20), RD(21), L, H);
    @(posedge clk); #1;   // startup cycle
    b_cycle = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) chk("lock first grant A", 32'(bus.a_waitrequest), 32'd0);
      if (!bus.b_waitrequest && b_cycle == 0) b_cycle = n;
      @(posedge clk); #1;
      if (b_cycle != 0) break;
    end
    chk("lock B grant cycle", 32'(b_cycle), 32'd65);
    @(negedge clk);
    chk("lock relock grants A", 32'(bus.a_waitrequest), 32'd0);
    drive(IDLE(), IDLE(), L, L);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
